// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: opcode constants, FSM state type and opcode legality
// shared by instruction fetch and instruction decode.
package instruction_fetch_pkg;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OPC_ADD  = 3'd0;
    localparam logic [OPC_W-1:0] OPC_ADDI = 3'd1;
    localparam logic [OPC_W-1:0] OPC_SW   = 3'd2;
    localparam logic [OPC_W-1:0] OPC_LW   = 3'd3;
    localparam logic [OPC_W-1:0] OPC_SLL  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} fetch_state_t;

    function automatic logic opcode_legal(input logic [OPC_W-1:0] op);
        return op <= OPC_SLL;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-to-decode valid/ready instruction channel.
//   valid  : inst/opcode/pc hold an instruction
//   ready  : decode accepts this cycle (transfer = valid & ready)
//   inst   : instruction word
//   opcode : top OPC_W bits of inst
//   pc     : address inst was fetched from
// master = fetch side, slave = decode side.
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int INST_W = 16
) ();
    logic              valid;
    logic              ready;
    logic [INST_W-1:0] inst;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] pc;

    modport master (output valid, inst, opcode, pc, input ready);
    modport slave  (input valid, inst, opcode, pc, output ready);
endinterface

// File: rtl/instruction_fetch_fetch_queue.sv
// fetch_queue: 2-entry FIFO of {pc, inst} between memory return and decode.
//   clk, rst_n : clock, async active-low reset
//   push/wdata : write tail
//   pop        : remove head (only while not empty)
//   rdata      : head entry
//   count      : occupancy 0..2
//   full/empty : occupancy flags
module fetch_queue #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) wp <= ~wp;
            if (pop) rp <= ~rp;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset; consumers gate the head with empty.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    assign rdata = mem[rp];
    assign full  = count == 2'd2;
    assign empty = count == 2'd0;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: walks a PC through a synchronous-read instruction memory,
// buffers returned words in a 2-entry queue and presents them to decode.
//   clk, rst_n  : clock, async active-low reset
//   start       : begin a run at PC 0 (only from IDLE or DONE)
//   imem_en     : memory read strobe
//   imem_addr   : memory read address
//   imem_rdata  : read data, valid one cycle after imem_en
//   id          : decode channel (master side)
//   busy        : run in progress
//   done        : all PROG_LEN instructions transferred
//   illegal     : sticky, an opcode outside the ISA has been presented
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int INST_W   = 16,
    parameter int PROG_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INST_W-1:0]  imem_rdata,
    instruction_fetch_if.master id,
    output logic               busy,
    output logic               done,
    output logic               illegal
);
    localparam int QW = ADDR_W + INST_W;
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] fl_pc;
    logic              in_flight;
    logic              illegal_q;
    logic              issue;
    logic              pop;
    logic              restart;
    logic              bad_now;
    logic              full;
    logic              empty;
    logic [1:0]        count;
    logic [QW-1:0]     head;

    assign pop     = id.valid & id.ready;
    assign restart = start & (state == S_IDLE || state == S_DONE);
    assign bad_now = id.valid & ~opcode_legal(id.opcode);

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: begin
                // Room for one more word after this cycle's pop:
                // occupancy + in_flight + 1 - pop <= 2.
                issue = pop | (~full & ~(in_flight & ~empty));
                if (issue && pc == LAST_PC) state_nx = S_DRAIN;
            end
            // Finish as soon as the queue will be empty after this cycle.
            S_DRAIN: if (!in_flight && (empty || (count == 2'd1 && pop))) state_nx = S_DONE;
            S_DONE:  if (start) state_nx = S_FETCH;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            fl_pc     <= '0;
            in_flight <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nx;
            in_flight <= issue;
            if (issue) begin
                fl_pc <= pc;
                pc    <= pc + ADDR_W'(1);
            end
            if (restart) begin
                pc        <= '0;
                illegal_q <= 1'b0;
            end else if (bad_now) begin
                illegal_q <= 1'b1;
            end
        end
    end

    fetch_queue #(.W(QW)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_flight),
        .wdata ({fl_pc, imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign imem_en   = issue;
    assign imem_addr = issue ? pc : '0;
    assign id.valid  = ~empty;
    assign {id.pc, id.inst} = empty ? '0 : head;
    assign id.opcode = id.inst[INST_W-1 -: OPC_W];
    assign busy      = state == S_FETCH || state == S_DRAIN;
    assign done      = state == S_DONE;
    // Rises in the same cycle the illegal word is presented.
    assign illegal   = illegal_q | bad_now;
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Producer side of the 3-bit-opcode instruction interface; feeds the instruction decode stage. Walks a PC through a synchronous-read instruction memory and buffers returned words in a 2-entry queue. Presents them to decode with a valid/ready handshake so the decoder or hazard logic can stall fetch. Flags opcodes outside the five-instruction ISA: ADD=0, ADDI=1, SW=2, LW=3, SLL=4.

Parameters:
ADDR_W, 8, PC / instruction-memory address width (word addressed)
INST_W, 16, instruction word width; opcode is bits [INST_W-1:INST_W-3]
PROG_LEN, 16, number of instructions fetched per run (1..2^ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin a run at PC 0 (ignored unless IDLE or DONE)
imem_en  out  1  memory read strobe
imem_addr  out  ADDR_W  memory read address
imem_rdata  in  INST_W  read data, valid exactly 1 cycle after imem_en
id_valid  out  1  id_inst/id_opcode/id_pc hold a valid instruction
id_ready  in  1  decode accepts this cycle (transfer = id_valid & id_ready)
id_inst  out  INST_W  instruction word
id_opcode  out  3  opcode field of id_inst
id_pc  out  ADDR_W  address id_inst was fetched from
busy  out  1  run in progress
done  out  1  all PROG_LEN instructions transferred; held until next start
illegal  out  1  sticky: an opcode 5..7 has been presented; cleared by start

Behaviour:
- Reset (async, rst_n=0): state IDLE, PC=0, queue empty, in-flight=0. All outputs 0: imem_en, imem_addr, id_valid, id_inst, id_opcode, id_pc, busy, done, illegal.
- FSM:
  - IDLE -> FETCH on start.
  - FETCH -> DRAIN when the last address (PROG_LEN-1) is issued.
  - DRAIN -> DONE when the queue is empty and nothing is in flight.
  - DONE -> FETCH on start. This clears done and illegal and sets PC=0.
- busy=1 in FETCH and DRAIN. done=1 in DONE only.
- Issue rule, in FETCH: imem_en=1 and imem_addr=PC when (queue occupancy + in-flight + 1 - pop_this_cycle) <= 2. PC increments on each issue. In-flight is 0 or 1.
- Return path: the cycle after an issue, imem_rdata is written to the queue tail with its PC. Return of a read is never blocked; the issue rule guarantees space.
- Queue: 2 entries, FIFO order. Head drives id_*; id_valid = not empty. Outputs are stable while id_valid & !id_ready.
  - Push and pop in the same cycle at occupancy 1 or 2: occupancy unchanged, order preserved.
  - Push into an empty queue: visible on id_* the following cycle, so fetch-to-decode latency is 2 cycles from imem_en.
- Throughput: with id_ready held high, one transfer per cycle after the 2-cycle latency.
- Backpressure: id_ready=0 for N cycles stops issue once the queue is full. No instruction is lost or duplicated.
- illegal: set on any cycle id_valid=1 and id_opcode>4. The instruction is still presented and transferred normally; decoding it is the decoder's concern.
- PC arithmetic: ADDR_W bits, unsigned. PROG_LEN=2^ADDR_W issues the last address 2^ADDR_W-1 and stops; PC never wraps into a reissue.
- start while busy: ignored.
- Reset mid-run: immediate abort to the reset state. Queued instructions are discarded. An in-flight read return is ignored.

Decomposition:
- Shared package: opcode constants OPC_ADD=0, OPC_ADDI=1, OPC_SW=2, OPC_LW=3, OPC_SLL=4, OPC_W=3, and a function for opcode legality (opcode<=4). These are shared with instruction decode.
- Sub-module fetch_queue: 2-entry FIFO of {pc, inst} with push, pop, count, full/empty. This is the natural split; the FSM and issue logic stay in the top.

Test Plan:
- Streaming: PROG_LEN=4, memory {0x0000,0x2000,0x4000,0x6000}, id_ready=1, pulse start. Expect imem_addr 0,1,2,3 on consecutive cycles; id_valid from 2 cycles after the first imem_en; id_opcode 0,1,2,3 with id_pc 0..3 on 4 consecutive cycles; done=1 one cycle after the last transfer; busy=0.
- Backpressure: same program, id_ready=0 for 5 cycles after the first valid. Expect exactly 2 issues, then imem_en=0; id_inst holds 0x0000. On id_ready=1, the remaining transfers arrive in order with no gap after the queue refills.
- Alternating ready: id_ready toggles every cycle over PROG_LEN=8. Expect 8 transfers with the id_pc sequence 0..7 exactly, no duplicates, and done at the end.
- Illegal opcode: word 2 = 0xA000 (opcode 5). Expect illegal to rise the cycle it is presented and stay 1 after done. The next start clears it.
- Reset mid-run: assert rst_n=0 with 2 queued and 1 in flight. Expect all outputs 0 asynchronously. After release and a new start, the first transfer is id_pc=0.
- Boundary: ADDR_W=2, PROG_LEN=4. Expect addresses 0..3 issued exactly once, no address-0 reissue, and done asserted. A start while busy has no effect.
